jtframe_pll_phase_ctrl: RTL and testbench
=========================================

# jtframe_pll_phase_ctrl

Runtime phase-shift sequencer for the SDRAM clock output of the system PLL. It converts a signed step request into the altpll dynamic phase-shift handshake (`phasecounterselect`/`phaseupdown`/`phasestep`/`phasedone`). It tracks the accumulated offset from the compile-time SDRAM shift and aborts cleanly on loss of lock. It sits next to the PLL, clocked by the PLL scan clock, and is driven by the OSD/debug register bus for SDRAM timing calibration.

## Interface
Parameters:
- `CNTSEL`, 3'd3, counter select driven on `phasecounterselect` (C1 = SDRAM clock).
- `POS_W`, 8, width of signed position accumulator.
- `MAX_POS`, 63, absolute position limit in steps; must satisfy MAX_POS < 2^(POS_W-1).
- `TMO`, 255, cycles allowed per `phasedone` edge wait before error.
- `BOOT_STEPS`, 0, signed boot offset in steps, used only with `JTFRAME_PLL_AUTOSTEP_EN`.

Ports:
- `clk`  in  1  scan clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL lock, already synchronised to `clk`.
- `req`  in  1  request strobe, sampled only when accepted.
- `req_steps`  in  POS_W  signed step count; positive = later phase.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle pulse on completion.
- `err`  out  1  one-cycle pulse on rejection, timeout or lock loss.
- `pos`  out  POS_W  signed accumulated offset in steps.
- `phasecounterselect`  out  3  constant `CNTSEL`.
- `phaseupdown`  out  1  1 = up (positive step).
- `phasestep`  out  1  PLL step strobe.
- `phasedone`  in  1  PLL handshake, active-high when idle.

## Operation
FSM states: IDLE, SETUP, STEP, WAIT_LO, WAIT_HI, GAP.
- IDLE: accept when `req && pll_locked && !busy`.
  - Latch |req_steps| into remaining counter and sign into `phaseupdown`.
  - Target `pos+req_steps` outside ±MAX_POS: no steps, `err` pulse, stay IDLE.
  - `req_steps==0`: `done` pulse next cycle, no `phasestep`.
  - Otherwise go to SETUP.
- `req` while not locked or busy: ignored; no queueing.
- SETUP (1 cycle): select/direction stable before strobe.
- STEP (2 cycles): `phasestep`=1.
- WAIT_LO: wait for `phasedone`=0. WAIT_HI: wait for `phasedone`=1. Each has its own TMO counter; expiry → `err`, IDLE, `pos` keeps last completed value.
- On `phasedone` rising in WAIT_HI: `pos` ±1, remaining −1.
  - remaining becomes 0: `done` pulse, IDLE.
  - Else GAP (1 cycle, strobe low), then STEP.
- `pll_locked` low in any state: next cycle IDLE, `phasestep`=0, `pos`=0 (relock restores compile-time phase), `err` pulse if not in IDLE.
- `done` and `err` are never asserted in the same cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `pos`=0, `phasestep`=0, `phaseupdown`=0; `phasecounterselect`=CNTSEL always.
- Acceptance at edge N: `busy`=1 from N+1. SETUP is N+1. `phasestep` is high at N+2 and N+3.
- Per step: 1 (SETUP, first step only) + 2 + t_lo + t_hi cycles, plus 1 GAP between steps.
- `busy` drops in the same cycle `done`/`err` rises. A new `req` is accepted that cycle+1 at earliest.
- Zero-step request: `done` at N+1. `busy` stays 0.
- Range rejection: `err` at N+1. `busy` stays 0.
- `rst` mid-sequence: next edge all outputs at reset values, `phasestep` low.
- `pos` updates on the edge after `phasedone` is seen high.

## Configuration
- `JTFRAME_PLL_AUTOSTEP_EN` defined:
  - On every `pll_locked` rising edge, the controller auto-issues a BOOT_STEPS request (same FSM). BOOT_STEPS is clipped to ±MAX_POS.
  - `busy` is high throughout. External `req` is ignored until its `done`.
  - Lock loss restarts this sequence at the next lock.
- Undefined: no automatic request. BOOT_STEPS is unused; `pos` starts at 0 after lock.

## Test plan
- Locked, req_steps=+3, PLL model drops phasedone for 4 cycles per step → three 2-cycle `phasestep` pulses, `phaseupdown`=1, `pos`=3, single `done`, `busy` low after.
- pos=60, req_steps=+5 (MAX_POS=63) → `err` at N+1, no `phasestep`, `pos` stays 60; then req_steps=−60 → `pos`=0, `done`.
- Model never lowers phasedone, TMO=255 → `err` 256 cycles after WAIT_LO entry, `pos` unchanged, FSM IDLE.
- req_steps=+10, deassert `pll_locked` after 4th step → `err` next cycle, `pos`=0, `phasestep` low; requests ignored until relock.
- req_steps=0 → `done` at N+1, `busy` never high, no strobe. `req` while unlocked → no response.
- With `JTFRAME_PLL_AUTOSTEP_EN`, BOOT_STEPS=−4: lock rise → four down steps, `pos`=−4, external `req` during sequence ignored. Without the macro: `pos`=0, no strobe.

Source files
------------

// File: rtl/jtframe_pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// jtframe_pll_phase_ctrl
//
// Runtime phase-shift sequencer for the SDRAM clock output of the system PLL.
// A signed step request is turned into the altpll dynamic phase-shift
// handshake (phasecounterselect / phaseupdown / phasestep / phasedone). The
// controller tracks the accumulated offset from the compile-time SDRAM shift
// and aborts cleanly when the PLL loses lock. It runs on the PLL scan clock.
//
// Optional feature macro: JTFRAME_PLL_AUTOSTEP_EN
//   When defined, every pll_locked rising edge issues an automatic request of
//   BOOT_STEPS (clipped to +/-MAX_POS) through the same sequencer. While it
//   runs, busy is high and external requests are ignored.
//
// Ports
//   clk                 scan clock, all logic on the rising edge
//   rst                 synchronous active-high reset
//   pll_locked          PLL lock, already synchronised to clk
//   req                 request strobe, sampled only when it can be accepted
//   req_steps           signed step count, positive = later phase
//   busy                a request is in progress
//   done                one-cycle pulse on completion
//   err                 one-cycle pulse on rejection, timeout or lock loss
//   pos                 signed accumulated offset in steps
//   phasecounterselect  constant CNTSEL
//   phaseupdown         1 = step up (positive direction)
//   phasestep           PLL step strobe (two cycles per step)
//   phasedone           PLL handshake, high when the PLL is idle
// ---------------------------------------------------------------------------
module jtframe_pll_phase_ctrl #(
  parameter logic [2:0] CNTSEL     = 3'd3,
  parameter int         POS_W      = 8,
  parameter int         MAX_POS    = 63,
  parameter int         TMO        = 255,
  parameter int         BOOT_STEPS = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic                    req,
  input  logic signed [POS_W-1:0] req_steps,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic signed [POS_W-1:0] pos,
  output logic [2:0]              phasecounterselect,
  output logic                    phaseupdown,
  output logic                    phasestep,
  input  logic                    phasedone
);

  localparam int TMO_W = (TMO < 1) ? 1 : $clog2(TMO + 1);

  localparam logic [TMO_W-1:0]     TMO_L   = TMO_W'(TMO);
  localparam logic signed [POS_W:0] MAX_L  = (POS_W + 1)'(MAX_POS);
  localparam logic [POS_W-1:0]     ONE_U   = POS_W'(1);

`ifdef JTFRAME_PLL_AUTOSTEP_EN
  localparam int BOOT_INT = (BOOT_STEPS >  MAX_POS) ?  MAX_POS :
                            (BOOT_STEPS < -MAX_POS) ? -MAX_POS : BOOT_STEPS;
  localparam logic signed [POS_W-1:0] BOOT_CLIP = POS_W'(BOOT_INT);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP,
    WAIT_LO,
    WAIT_HI,
    GAP
  } state_t;

  state_t                    state_q, state_d;
  logic [POS_W-1:0]          remain_q, remain_d;   // steps still to issue
  logic [TMO_W-1:0]          tmo_q, tmo_d;         // cycles spent in a wait state
  logic                      half_q, half_d;       // second cycle of STEP
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic                      dir_q, dir_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      phasestep_q;

  logic                      start;
  logic signed [POS_W-1:0]   start_steps;
  logic signed [POS_W:0]     target;

`ifdef JTFRAME_PLL_AUTOSTEP_EN
  logic                      locked_q;
  logic                      auto_go;

  // The state is always IDLE on a lock rising edge, since lock loss forces
  // IDLE, so the automatic request is accepted the same cycle it is raised.
  assign auto_go = pll_locked & ~locked_q;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    remain_d    = remain_q;
    tmo_d       = tmo_q;
    half_d      = half_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

`ifdef JTFRAME_PLL_AUTOSTEP_EN
    start       = auto_go | req;
    start_steps = auto_go ? BOOT_CLIP : req_steps;
`else
    start       = req;
    start_steps = req_steps;
`endif

    // Target is computed one bit wider so the range check cannot wrap.
    target = {pos_q[POS_W-1], pos_q} + {start_steps[POS_W-1], start_steps};

    if (!pll_locked) begin
      // A relock restores the compile-time phase, so the offset is cleared.
      state_d = IDLE;
      pos_d   = '0;
      err_d   = (state_q != IDLE);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (target > MAX_L || target < -MAX_L) begin
              err_d = 1'b1;
            end else if (start_steps == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = SETUP;
              dir_d    = ~start_steps[POS_W-1];
              remain_d = start_steps[POS_W-1] ? POS_W'(-start_steps)
                                              : POS_W'(start_steps);
            end
          end
        end

        // One cycle with select and direction stable ahead of the strobe.
        SETUP: begin
          state_d = STEP;
          half_d  = 1'b0;
        end

        STEP: begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            state_d = WAIT_LO;
            tmo_d   = '0;
          end
        end

        WAIT_LO: begin
          if (!phasedone) begin
            state_d = WAIT_HI;
            tmo_d   = '0;
          end else if (tmo_q == TMO_L) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end

        WAIT_HI: begin
          if (phasedone) begin
            pos_d    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            remain_d = remain_q - ONE_U;
            if (remain_q == ONE_U) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else if (tmo_q == TMO_L) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end

        GAP: begin
          state_d = STEP;
          half_d  = 1'b0;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      tmo_q       <= '0;
      half_q      <= 1'b0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      phasestep_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      remain_q    <= remain_d;
      tmo_q       <= tmo_d;
      half_q      <= half_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      err_q       <= err_d;
      // Registered so the PLL sees a clean strobe straight from a flop.
      phasestep_q <= (state_d == STEP);
    end
  end

`ifdef JTFRAME_PLL_AUTOSTEP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= pll_locked;
    end
  end
`endif

  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign err                = err_q;
  assign pos                = pos_q;
  assign phaseupdown        = dir_q;
  assign phasestep          = phasestep_q;
  assign phasecounterselect = CNTSEL;

endmodule

// File: tb/tb_jtframe_pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jtframe_pll_phase_ctrl
//
// Directed bench for jtframe_pll_phase_ctrl. A small PLL model answers each
// phasestep by dropping phasedone for four cycles; a monitor counts strobes,
// strobe widths and done/err pulses. Stimulus and checks are done half a
// clock away from the rising edge.
// ---------------------------------------------------------------------------
module tb_jtframe_pll_phase_ctrl;

  localparam int POS_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    pll_locked;
  logic                    req;
  logic signed [POS_W-1:0] req_steps;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic signed [POS_W-1:0] pos;
  logic [2:0]              phasecounterselect;
  logic                    phaseupdown;
  logic                    phasestep;
  logic                    phasedone;

  int total = 0;
  int bad   = 0;

  jtframe_pll_phase_ctrl #(
    .CNTSEL    (3'd3),
    .POS_W     (POS_W),
    .MAX_POS   (63),
    .TMO       (255),
    .BOOT_STEPS(-4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pll_locked        (pll_locked),
    .req               (req),
    .req_steps         (req_steps),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .pos               (pos),
    .phasecounterselect(phasecounterselect),
    .phaseupdown       (phaseupdown),
    .phasestep         (phasestep),
    .phasedone         (phasedone)
  );

  always #5 clk = ~clk;

  // PLL model: on a new strobe, phasedone goes low for four cycles.
  logic model_en   = 1'b1;
  logic step_seen  = 1'b0;
  int   pd_cnt     = 0;

  always @(negedge clk) begin
    if (!model_en) begin
      phasedone = 1'b1;
      pd_cnt    = 0;
    end else if (pd_cnt > 0) begin
      pd_cnt = pd_cnt - 1;
      if (pd_cnt == 0) phasedone = 1'b1;
    end else if (phasestep && !step_seen) begin
      phasedone = 1'b0;
      pd_cnt    = 4;
    end
    if (phasestep) step_seen = 1'b1;
    else           step_seen = 1'b0;
  end

  // Monitor
  int   step_cnt  = 0;
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   width_bad = 0;
  int   cur_w     = 0;
  logic ps_prev   = 1'b0;

  always @(negedge clk) begin
    if (phasestep) begin
      if (!ps_prev) step_cnt = step_cnt + 1;
      cur_w = cur_w + 1;
    end else begin
      if (ps_prev && cur_w != 2) width_bad = width_bad + 1;
      cur_w = 0;
    end
    if (done) done_cnt = done_cnt + 1;
    if (err)  err_cnt  = err_cnt + 1;
    ps_prev = phasestep;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    step_cnt  = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    width_bad = 0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    req        = 1'b0;
    req_steps  = '0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
    total++; if (pos !== 8'sd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    total++; if (phasestep !== 1'b0) begin bad++; $display("FAIL reset_phasestep got=%0b exp=0", phasestep); end
    total++; if (phaseupdown !== 1'b0) begin bad++; $display("FAIL reset_updown got=%0b exp=0", phaseupdown); end
    total++; if (phasecounterselect !== 3'd3) begin bad++; $display("FAIL reset_cntsel got=%0d exp=3", phasecounterselect); end
    rst = 1'b0;
    tick();
  endtask

  // +3 steps: SETUP at N+1, strobe at N+2/N+3, three 2-cycle pulses.
  task automatic test_plus3();
    int i;
    pll_locked = 1'b1;
    repeat (3) tick();
    clear_counts();
    req = 1'b1; req_steps = 8'sd3;
    tick();                                   // cycle N+1
    req = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL p3_busy_n1 got=%0b exp=1", busy); end
    total++; if (phasestep !== 1'b0) begin bad++; $display("FAIL p3_step_n1 got=%0b exp=0", phasestep); end
    total++; if (phaseupdown !== 1'b1) begin bad++; $display("FAIL p3_updown got=%0b exp=1", phaseupdown); end
    tick();                                   // N+2
    total++; if (phasestep !== 1'b1) begin bad++; $display("FAIL p3_step_n2 got=%0b exp=1", phasestep); end
    tick();                                   // N+3
    total++; if (phasestep !== 1'b1) begin bad++; $display("FAIL p3_step_n3 got=%0b exp=1", phasestep); end
    tick();                                   // N+4
    total++; if (phasestep !== 1'b0) begin bad++; $display("FAIL p3_step_n4 got=%0b exp=0", phasestep); end
    for (i = 0; i < 200; i++) begin
      if (done || err) break;
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL p3_done got=%0b exp=1 (waited %0d)", done, i); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL p3_busy_at_done got=%0b exp=0", busy); end
    total++; if (pos !== 8'sd3) begin bad++; $display("FAIL p3_pos got=%0d exp=3", pos); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL p3_done_pulse got=%0b exp=0", done); end
    total++; if (step_cnt !== 3) begin bad++; $display("FAIL p3_step_cnt got=%0d exp=3", step_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL p3_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL p3_err_cnt got=%0d exp=0", err_cnt); end
    total++; if (width_bad !== 0) begin bad++; $display("FAIL p3_step_width got=%0d exp=0", width_bad); end
  endtask

  // Reset in the middle of a strobe returns everything to reset values.
  task automatic test_rst_mid();
    req = 1'b1; req_steps = 8'sd2;
    tick();                                   // N+1
    req = 1'b0;
    tick();                                   // N+2, strobe high
    rst = 1'b1;
    tick();
    total++; if (phasestep !== 1'b0) begin bad++; $display("FAIL rst_mid_step got=%0b exp=0", phasestep); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
    total++; if (pos !== 8'sd0) begin bad++; $display("FAIL rst_mid_pos got=%0d exp=0", pos); end
    total++; if (phaseupdown !== 1'b0) begin bad++; $display("FAIL rst_mid_updown got=%0b exp=0", phaseupdown); end
    rst = 1'b0;
    repeat (8) tick();
  endtask

  // Range: reach +60, reject +5, then return with -60.
  task automatic test_range();
    int i;
    req = 1'b1; req_steps = 8'sd60;
    tick();
    req = 1'b0;
    for (i = 0; i < 2000; i++) begin
      if (done || err) break;
      tick();
    end
    total++; if (pos !== 8'sd60) begin bad++; $display("FAIL rng_pos60 got=%0d exp=60", pos); end
    repeat (2) tick();
    clear_counts();
    req = 1'b1; req_steps = 8'sd5;
    tick();                                   // N+1
    req = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rng_err got=%0b exp=1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rng_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rng_done got=%0b exp=0", done); end
    repeat (4) tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rng_err_pulse got=%0b exp=0", err); end
    total++; if (step_cnt !== 0) begin bad++; $display("FAIL rng_no_step got=%0d exp=0", step_cnt); end
    total++; if (pos !== 8'sd60) begin bad++; $display("FAIL rng_pos_kept got=%0d exp=60", pos); end
    clear_counts();
    req = 1'b1; req_steps = -8'sd60;
    tick();
    req = 1'b0;
    for (i = 0; i < 2000; i++) begin
      if (done || err) break;
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rng_back_done got=%0b exp=1", done); end
    total++; if (pos !== 8'sd0) begin bad++; $display("FAIL rng_back_pos got=%0d exp=0", pos); end
    total++; if (phaseupdown !== 1'b0) begin bad++; $display("FAIL rng_back_updown got=%0b exp=0", phaseupdown); end
    tick();
    total++; if (step_cnt !== 60) begin bad++; $display("FAIL rng_back_steps got=%0d exp=60", step_cnt); end
  endtask

  // phasedone never drops: WAIT_LO entered at N+4, err at N+260.
  task automatic test_timeout();
    int j;
    model_en = 1'b0;
    tick();
    clear_counts();
    req = 1'b1; req_steps = 8'sd1;
    for (j = 1; j <= 400; j++) begin
      tick();
      req = 1'b0;
      if (err) break;
    end
    total++; if (j !== 260) begin bad++; $display("FAIL tmo_cycle got=%0d exp=260", j); end
    total++; if (pos !== 8'sd0) begin bad++; $display("FAIL tmo_pos got=%0d exp=0", pos); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%0b exp=0", busy); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_pulse got=%0b exp=0", err); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL tmo_done_cnt got=%0d exp=0", done_cnt); end
    total++; if (step_cnt !== 1) begin bad++; $display("FAIL tmo_step_cnt got=%0d exp=1", step_cnt); end
    model_en = 1'b1;
    repeat (2) tick();
  endtask

  // Lock loss after the 4th of 10 steps, requests ignored while unlocked.
  task automatic test_lock_loss();
    int i;
    logic saw_busy;
    clear_counts();
    req = 1'b1; req_steps = 8'sd10;
    tick();
    req = 1'b0;
    for (i = 0; i < 400; i++) begin
      if (pos == 8'sd4 || err || done) break;
      tick();
    end
    total++; if (pos !== 8'sd4) begin bad++; $display("FAIL ll_reach4 got=%0d exp=4", pos); end
    pll_locked = 1'b0;
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ll_err got=%0b exp=1", err); end
    total++; if (pos !== 8'sd0) begin bad++; $display("FAIL ll_pos got=%0d exp=0", pos); end
    total++; if (phasestep !== 1'b0) begin bad++; $display("FAIL ll_step got=%0b exp=0", phasestep); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ll_busy got=%0b exp=0", busy); end
    req = 1'b1; req_steps = 8'sd2;
    saw_busy = 1'b0;
    repeat (6) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    req = 1'b0;
    total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL ll_unlocked_busy got=%0b exp=0", saw_busy); end
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL ll_err_cnt got=%0d exp=1", err_cnt); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL ll_done_cnt got=%0d exp=0", done_cnt); end
    total++; if (step_cnt !== 4) begin bad++; $display("FAIL ll_step_cnt got=%0d exp=4", step_cnt); end
    pll_locked = 1'b1;
    repeat (6) tick();
    req = 1'b1; req_steps = 8'sd2;
    tick();
    req = 1'b0;
    for (i = 0; i < 200; i++) begin
      if (done || err) break;
      tick();
    end
    total++; if (pos !== 8'sd2) begin bad++; $display("FAIL ll_relock_pos got=%0d exp=2", pos); end
    tick();
  endtask

  // Zero-step request: done at N+1, busy never high, no strobe.
  task automatic test_zero();
    logic saw_busy;
    clear_counts();
    req = 1'b1; req_steps = 8'sd0;
    tick();                                   // N+1
    req = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%0b exp=0", busy); end
    saw_busy = 1'b0;
    repeat (4) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL zero_busy_later got=%0b exp=0", saw_busy); end
    total++; if (step_cnt !== 0) begin bad++; $display("FAIL zero_steps got=%0d exp=0", step_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (pos !== 8'sd2) begin bad++; $display("FAIL zero_pos got=%0d exp=2", pos); end
  endtask

  // Behaviour on a lock rising edge, with and without the boot sequence.
  task automatic test_autostep();
    int i;
    logic busy_gap;
    pll_locked = 1'b0;
    repeat (3) tick();
    clear_counts();
`ifdef JTFRAME_PLL_AUTOSTEP_EN
    pll_locked = 1'b1;
    req = 1'b1; req_steps = 8'sd5;
    busy_gap = 1'b0;
    for (i = 0; i < 300; i++) begin
      tick();
      if (done || err) break;
      if (!busy) busy_gap = 1'b1;
    end
    req = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL auto_done got=%0b exp=1", done); end
    total++; if (pos !== -8'sd4) begin bad++; $display("FAIL auto_pos got=%0d exp=-4", pos); end
    total++; if (phaseupdown !== 1'b0) begin bad++; $display("FAIL auto_updown got=%0b exp=0", phaseupdown); end
    total++; if (busy_gap !== 1'b0) begin bad++; $display("FAIL auto_busy_gap got=%0b exp=0", busy_gap); end
    tick();
    total++; if (step_cnt !== 4) begin bad++; $display("FAIL auto_steps got=%0d exp=4", step_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL auto_done_cnt got=%0d exp=1", done_cnt); end
`else
    pll_locked = 1'b1;
    busy_gap = 1'b0;
    for (i = 0; i < 20; i++) begin
      tick();
      if (busy) busy_gap = 1'b1;
    end
    total++; if (pos !== 8'sd0) begin bad++; $display("FAIL noauto_pos got=%0d exp=0", pos); end
    total++; if (step_cnt !== 0) begin bad++; $display("FAIL noauto_steps got=%0d exp=0", step_cnt); end
    total++; if (busy_gap !== 1'b0) begin bad++; $display("FAIL noauto_busy got=%0b exp=0", busy_gap); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL noauto_done got=%0d exp=0", done_cnt); end
`endif
  endtask

  initial begin
    phasedone = 1'b1;
    test_reset();
`ifdef JTFRAME_PLL_AUTOSTEP_EN
    test_autostep();
`else
    test_plus3();
    test_rst_mid();
    test_range();
    test_timeout();
    test_lock_loss();
    test_zero();
    test_autostep();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
